// File: rtl/rs_iter_ctrl_if.sv
// Handshake and step-unit bundle for rs_iter_ctrl.
//   in_valid/in_ready/in_data : operand source side
//   out_valid/out_ready/out_data/out_iters : result consumer side
//   step_in/step_prev/step_out : shared Newton-step unit (step_out is combinational)
//   busy : controller not idle
// master = environment (source, consumer, step unit), slave = controller.
interface rs_iter_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] step_in;
  logic [31:0] step_prev;
  logic [31:0] step_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_iters;
  logic        busy;

  modport master (
    output in_valid, in_data, out_ready, step_out,
    input  in_ready, step_in, step_prev, out_valid, out_data, out_iters, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, step_out,
    output in_ready, step_in, step_prev, out_valid, out_data, out_iters, busy
  );
endinterface

// File: rtl/rs_iter_ctrl.sv
// Iterative sequencer for a binary32 square root: drives one shared Newton-step
// unit from a fixed seed until the estimate repeats or ITER_MAX is reached, and
// answers special operands (zero, denormal, NaN, negative, +inf) directly.
// Ports: clk, rst (async, active high), bus (rs_iter_ctrl_if.slave).
module rs_iter_ctrl #(
  parameter int unsigned ITER_MAX   = 10,
  parameter logic [31:0] INIT_GUESS = 32'h3F800000
) (
  input logic           clk,
  input logic           rst,
  rs_iter_ctrl_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t        state, state_d;
  logic [DW-1:0] a_q, a_d, x_q, x_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d, iters_q, iters_d, cnt_inc;
  logic          valid_q, valid_d, ready_q, ready_d, busy_q, busy_d;
  logic          is_special;
  logic [DW-1:0] special_val;

  // Classify the offered operand; only used on the accept edge.
  always_comb begin
    is_special  = 1'b1;
    special_val = '0;
    if (bus.in_data[30:23] == 8'h00) begin
      special_val = (bus.in_data[22:0] == 23'd0) ? bus.in_data : 32'h00000000;
    end else if (bus.in_data[30:23] == 8'hFF && bus.in_data[22:0] != 23'd0) begin
      special_val = 32'h7FC00000;
    end else if (bus.in_data[31]) begin
      special_val = 32'h7FC00000;
    end else if (bus.in_data[30:23] == 8'hFF) begin
      special_val = 32'h7F800000;
    end else begin
      is_special = 1'b0;
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      iters_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      iters_q <= iters_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    a_d     = a_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    iters_d = iters_q;
    valid_d = valid_q;
    cnt_inc = cnt_q + CW'(1);
    case (state)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.in_valid && ready_q) begin
          a_d = bus.in_data;
          if (is_special) begin
            // Result shows up one cycle later, matching the one-iteration latency.
            data_d  = special_val;
            iters_d = '0;
            state_d = DONE;
          end else begin
            x_d     = INIT_GUESS;
            cnt_d   = '0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        x_d   = bus.step_out;
        cnt_d = cnt_inc;
        if (bus.step_out == x_q || cnt_inc == CW'(ITER_MAX)) begin
          data_d  = bus.step_out;
          iters_d = cnt_inc;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Handshake only counts once the result is actually presented.
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign bus.in_ready  = ready_q;
  assign bus.step_in   = a_q;
  assign bus.step_prev = x_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_iters = iters_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_rs_iter_ctrl.sv
// Directed bench for rs_iter_ctrl: a real-valued Newton step model feeds the
// default instance, an always-incrementing model feeds an ITER_MAX=3 instance.
module tb_rs_iter_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   edges;

  always #5 clk = ~clk;

  rs_iter_ctrl_if bus1 ();
  rs_iter_ctrl_if bus2 ();

  rs_iter_ctrl dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  rs_iter_ctrl #(.ITER_MAX(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(32'(f[30:23]) + 32'd896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    logic [31:0] b;
    logic        rnd;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF) return 32'h7FC00000;
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    b = {d[63], 8'(e), d[51:29]};
    rnd = d[28] && ((|d[27:0]) || d[29]);
    return b + 32'(rnd);
  endfunction

  function automatic logic [31:0] newton(input logic [31:0] a, input logic [31:0] x);
    real ar, xr;
    ar = f2r(a);
    xr = f2r(x);
    if (xr == 0.0) return 32'd0;
    return r2f(xr + ((ar / xr - xr) / 2.0));
  endfunction

  assign bus1.step_out = newton(bus1.step_in, bus1.step_prev);
  assign bus2.step_out = bus2.step_prev + 32'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Offer an operand to dut1 (in_ready must already be high) and pass the accept edge.
  task automatic send(input logic [31:0] a);
    bus1.in_valid = 1'b1;
    bus1.in_data  = a;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus1.in_data  = $urandom;
    check("accept_busy", 32'(bus1.busy), 32'd1);
    check("accept_in_ready", 32'(bus1.in_ready), 32'd0);
    check("accept_step_in", bus1.step_in, a);
  endtask

  // Count edges after the accept edge until out_valid; bounded.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!bus1.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!bus1.out_valid) check({tag, "_busy"}, 32'(bus1.busy), 32'd1);
    end
    check({tag, "_valid"}, 32'(bus1.out_valid), 32'd1);
  endtask

  task automatic take();
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check("take_valid", 32'(bus1.out_valid), 32'd0);
    check("take_busy", 32'(bus1.busy), 32'd0);
    check("take_in_ready", 32'(bus1.in_ready), 32'd1);
  endtask

  task automatic special(input logic [31:0] a, input logic [31:0] exp);
    send(a);
    wait_valid("spec", edges);
    check("spec_edges", 32'(edges), 32'd1);
    check("spec_data", bus1.out_data, exp);
    check("spec_iters", 32'(bus1.out_iters), 32'd0);
    take();
  endtask

  task automatic normal(input logic [31:0] a, input logic [31:0] exp);
    send(a);
    check("norm_seed", bus1.step_prev, 32'h3F800000);
    wait_valid("norm", edges);
    check("norm_data", bus1.out_data, exp);
    check("norm_iters_range", 32'(bus1.out_iters >= 4'd1 && bus1.out_iters <= 4'd10), 32'd1);
    check("norm_edges_eq_iters", 32'(edges), 32'(bus1.out_iters));
    take();
  endtask

  initial begin
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;

    // Reset values while rst is held
    #12;
    check("rst_valid", 32'(bus1.out_valid), 32'd0);
    check("rst_busy", 32'(bus1.busy), 32'd0);
    check("rst_data", bus1.out_data, 32'd0);
    check("rst_iters", 32'(bus1.out_iters), 32'd0);
    check("rst_prev", bus1.step_prev, 32'd0);
    check("rst_in", bus1.step_in, 32'd0);
    check("rst_in_ready", 32'(bus1.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus1.in_ready), 32'd1);

    // Unit seed converges on the first iteration
    send(32'h3F800000);
    check("unit_prev", bus1.step_prev, 32'h3F800000);
    wait_valid("unit", edges);
    check("unit_edges", 32'(edges), 32'd1);
    check("unit_data", bus1.out_data, 32'h3F800000);
    check("unit_iters", 32'(bus1.out_iters), 32'd1);
    take();

    normal(32'h40800000, 32'h40000000);
    normal(32'h41800000, 32'h40800000);
    normal(32'h40100000, 32'h3FC00000);

    special(32'hC0800000, 32'h7FC00000);
    special(32'h7F800000, 32'h7F800000);
    special(32'h80000000, 32'h80000000);
    special(32'h00000001, 32'h00000000);
    special(32'h00000000, 32'h00000000);
    special(32'h7FC00001, 32'h7FC00000);
    special(32'hFF800000, 32'h7FC00000);

    // Iteration cap on the ITER_MAX=3 instance with a never-repeating step
    check("cap_in_ready", 32'(bus2.in_ready), 32'd1);
    bus2.in_valid = 1'b1;
    bus2.in_data  = 32'h40800000;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    edges = 0;
    while (!bus2.out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("cap_edges", 32'(edges), 32'd3);
    check("cap_iters", 32'(bus2.out_iters), 32'd3);
    check("cap_data", bus2.out_data, 32'h3F800003);
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.out_ready = 1'b0;
    check("cap_release", 32'(bus2.out_valid), 32'd0);

    // Backpressure: result held, new operand waits, accepted one edge after release
    send(32'h40800000);
    wait_valid("bp", edges);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 32'h41800000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_data", bus1.out_data, 32'h40000000);
      check("bp_in_ready", 32'(bus1.in_ready), 32'd0);
      check("bp_valid", 32'(bus1.out_valid), 32'd1);
    end
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check("bp_rel_valid", 32'(bus1.out_valid), 32'd0);
    check("bp_rel_in_ready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    check("bp_next_busy", 32'(bus1.busy), 32'd1);
    check("bp_next_step_in", bus1.step_in, 32'h41800000);
    wait_valid("bp_next", edges);
    check("bp_next_data", bus1.out_data, 32'h40800000);
    take();

    // Reset in the middle of ITER discards the operand
    send(32'h40800000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", 32'(bus1.busy), 32'd1);
    check("mid_valid", 32'(bus1.out_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(bus1.out_valid), 32'd0);
    check("mrst_busy", 32'(bus1.busy), 32'd0);
    check("mrst_data", bus1.out_data, 32'd0);
    check("mrst_iters", 32'(bus1.out_iters), 32'd0);
    check("mrst_prev", bus1.step_prev, 32'd0);
    check("mrst_in", bus1.step_in, 32'd0);
    check("mrst_in_ready", 32'(bus1.in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("mrst_no_valid", 32'(bus1.out_valid), 32'd0);
    end
    check("mrst_ready_again", 32'(bus1.in_ready), 32'd1);
    normal(32'h41100000, 32'h40400000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
